// File: rtl/calc_port_master.sv
// calc_port_master: request driver for one calc1 port.
// Buffers {cmd, op1, op2} operations in a small FIFO and serializes each one
// onto the two-cycle calc1 request protocol. It then waits for the port's
// response, with a timeout, and returns the result on a valid/ready stream.
// Only one operation is outstanding at a time.
// Optional feature macro: CALC_CMD_FILTER_EN. When it is defined, commands
// outside {1,2,5,6} are answered locally with resp=2 and never reach calc1.
module calc_port_master #(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 2,
    parameter int CMD_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CMD_WIDTH-1:0]  s_cmd,
    input  logic [DATA_WIDTH-1:0] s_op1,
    input  logic [DATA_WIDTH-1:0] s_op2,
    output logic [CMD_WIDTH-1:0]  req_cmd_in,
    output logic [DATA_WIDTH-1:0] req_data_in,
    input  logic [RESP_WIDTH-1:0] out_resp,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RESP_WIDTH-1:0] m_resp,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_timeout,
    output logic                  busy,
    output logic                  spurious
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CMD, OP2, WAIT, HOLD} state_t;
    typedef struct packed {
        logic [CMD_WIDTH-1:0]  cmd;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
    } entry_t;

    entry_t                mem_q [FIFO_DEPTH];
    entry_t                head;
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           count_q;
    logic                  push, pop, resp_seen;
    state_t                state_q, state_d;
    logic [CMD_WIDTH-1:0]  cmd_q;
    logic [DATA_WIDTH-1:0] op1_q, op2_q;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  m_valid_q, m_valid_d, m_timeout_q, m_timeout_d;
    logic [RESP_WIDTH-1:0] m_resp_q, m_resp_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  spurious_q, spurious_d;

`ifdef CALC_CMD_FILTER_EN
    function automatic logic cmd_ok(input logic [CMD_WIDTH-1:0] c);
        return (c == CMD_WIDTH'(1)) || (c == CMD_WIDTH'(2)) ||
               (c == CMD_WIDTH'(5)) || (c == CMD_WIDTH'(6));
    endfunction
`endif

    // s_ready looks only at the count; a pop in the same cycle does not free a slot early
    assign s_ready   = (count_q != FULL);
    assign push      = s_valid && s_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign head      = mem_q[rptr_q];
    assign resp_seen = (out_resp != '0);

    // FIFO storage; contents need no reset because the pointers and count gate all reads
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= '{cmd: s_cmd, op1: s_op1, op2: s_op2};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // State register, working operands, result and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            timer_q     <= '0;
            m_valid_q   <= 1'b0;
            m_resp_q    <= '0;
            m_data_q    <= '0;
            m_timeout_q <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            m_valid_q   <= m_valid_d;
            m_resp_q    <= m_resp_d;
            m_data_q    <= m_data_d;
            m_timeout_q <= m_timeout_d;
            spurious_q  <= spurious_d;
            if (pop) begin
                cmd_q <= head.cmd;
                op1_q <= head.op1;
                op2_q <= head.op2;
            end
        end
    end

    // Next-state logic: a response in the final WAIT cycle takes priority over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pop) begin
`ifdef CALC_CMD_FILTER_EN
                state_d = cmd_ok(head.cmd) ? CMD : HOLD;
`else
                state_d = CMD;
`endif
            end
            CMD:  state_d = OP2;
            OP2:  state_d = WAIT;
            WAIT: if (resp_seen || (timer_q == TMAX)) state_d = HOLD;
            HOLD: if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timer, result capture and sticky spurious-response flag
    always_comb begin
        timer_d     = timer_q;
        m_valid_d   = m_valid_q;
        m_resp_d    = m_resp_q;
        m_data_d    = m_data_q;
        m_timeout_d = m_timeout_q;
        spurious_d  = spurious_q | (resp_seen && (state_q != WAIT));
        case (state_q)
`ifdef CALC_CMD_FILTER_EN
            IDLE: if (pop && !cmd_ok(head.cmd)) begin
                m_valid_d   = 1'b1;
                m_resp_d    = RESP_WIDTH'(2);
                m_data_d    = '0;
                m_timeout_d = 1'b0;
            end
`endif
            OP2: timer_d = '0;
            WAIT: begin
                if (resp_seen) begin
                    m_valid_d   = 1'b1;
                    m_resp_d    = out_resp;
                    m_data_d    = out_data;
                    m_timeout_d = 1'b0;
                end else if (timer_q == TMAX) begin
                    m_valid_d   = 1'b1;
                    m_resp_d    = '0;
                    m_data_d    = '0;
                    m_timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: if (m_ready) begin
                m_valid_d   = 1'b0;
                m_resp_d    = '0;
                m_data_d    = '0;
                m_timeout_d = 1'b0;
            end
            default: ;
        endcase
    end

    // calc1 request drive: command with op1, then op2, and idle zeros everywhere else
    always_comb begin
        req_cmd_in  = '0;
        req_data_in = '0;
        case (state_q)
            CMD: begin
                req_cmd_in  = cmd_q;
                req_data_in = op1_q;
            end
            OP2: req_data_in = op2_q;
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign m_valid   = m_valid_q;
    assign m_resp    = m_resp_q;
    assign m_data    = m_data_q;
    assign m_timeout = m_timeout_q;
    assign spurious  = spurious_q;

endmodule

// File: tb/tb_calc_port_master.sv
// Self-checking bench for calc_port_master with a scoreboard of expected results.
// Build with CALC_CMD_FILTER_EN defined to check the command-filter variant.
module tb_calc_port_master;
    localparam int DW = 32, RW = 2, CW = 4, FD = 4, TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, m_valid, m_ready, m_timeout, busy, spurious;
    logic [CW-1:0] s_cmd, req_cmd_in;
    logic [DW-1:0] s_op1, s_op2, req_data_in, out_data, m_data;
    logic [RW-1:0] out_resp, m_resp;

    typedef struct {
        logic [RW-1:0] resp;
        logic [DW-1:0] data;
        logic          to;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int n_chk = 0, n_fail = 0;

    calc_port_master #(.DATA_WIDTH(DW), .RESP_WIDTH(RW), .CMD_WIDTH(CW),
                       .FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_cmd(s_cmd), .s_op1(s_op1), .s_op2(s_op2),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(out_resp), .out_data(out_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_resp(m_resp), .m_data(m_data),
        .m_timeout(m_timeout), .busy(busy), .spurious(spurious)
    );

    always #5 clk = ~clk;

    // Drive one request (called at a negedge); returns at the negedge after acceptance.
    task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [RW-1:0] er, input logic [DW-1:0] ed, input logic eto);
        s_valid = 1'b1; s_cmd = c; s_op1 = a; s_op2 = b;
        for (int i = 0; i < 200 && !s_ready; i++) @(negedge clk);
        if (!s_ready) begin
            n_chk++; n_fail++;
            $display("FAIL push_accept: s_ready=%0b required 1 within 200 cycles", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        sb.push_back('{er, ed, eto});
    endtask

    // calc1 port model: watches the request pulse, replies resp_at cycles into WAIT
    // (resp_at<0: never), and returns at the first negedge with m_valid high.
    task automatic serve(input int resp_at, input logic [RW-1:0] r, input logic [DW-1:0] d,
                         output int ncmd, output logic [CW-1:0] cv, output logic [DW-1:0] d1,
                         output logic [DW-1:0] d2, output int cat, output int wcyc, output bit ok);
        int cc;
        cc = -1000; ncmd = 0; cv = '0; d1 = '0; d2 = '0; wcyc = -1; ok = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (m_valid) begin ok = 1'b1; wcyc = cyc - (cc + 2); break; end
            if (req_cmd_in != '0) begin ncmd++; cv = req_cmd_in; d1 = req_data_in; cc = cyc; end
            if (cyc == cc + 1) d2 = req_data_in;
            if (resp_at >= 0 && cyc == cc + 2 + resp_at) begin out_resp = r; out_data = d; end
            else begin out_resp = '0; out_data = '0; end
            @(negedge clk);
        end
        out_resp = '0; out_data = '0;
        cat = cc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
        n_chk++; if ({m_valid, m_timeout, busy, spurious} !== 4'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {m_valid, m_timeout, busy, spurious}); end
        n_chk++; if ({m_resp, m_data, req_cmd_in, req_data_in} !== '0) begin n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h want 0", m_resp, m_data, req_cmd_in, req_data_in); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int n, ca, w; logic [CW-1:0] cv; logic [DW-1:0] d1, d2; bit ok;
        push(4'd1, 32'd5, 32'd7, 2'd1, 32'd12, 1'b0);
        serve(1, 2'd1, 32'd12, n, cv, d1, d2, ca, w, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL add_mvalid: no m_valid within budget"); end
        n_chk++; if (n !== 1 || cv !== 4'd1) begin n_fail++; $display("FAIL add_cmd_pulse: got %0d cycles cmd %0d want 1 cycle cmd 1", n, cv); end
        n_chk++; if (d1 !== 32'd5 || d2 !== 32'd7) begin n_fail++; $display("FAIL add_operands: got %0d,%0d want 5,7", d1, d2); end
        n_chk++; if (ca !== 1) begin n_fail++; $display("FAIL add_cmd_latency: CMD at %0d want 1", ca); end
        n_chk++; if (w !== 2) begin n_fail++; $display("FAIL add_result_latency: got %0d want 2", w); end
        e = sb.pop_front();
        n_chk++; if (m_resp !== e.resp || m_data !== e.data || m_timeout !== e.to) begin n_fail++;
            $display("FAIL add_result: got %0d/%0d/%0b want %0d/%0d/%0b", m_resp, m_data, m_timeout, e.resp, e.data, e.to); end
        m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
        n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL add_handshake: m_valid=%0b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        int n, ca, w; logic [CW-1:0] cv; logic [DW-1:0] d1, d2, a, b; bit ok;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = DW'(i * 16 + 1); b = DW'(i + 100);
            s_valid = 1'b1; s_cmd = 4'd1; s_op1 = a; s_op2 = b;
            n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d: got %0b want 1", i, s_ready); end
            if (i == 0) sb.push_back('{2'd0, 32'd0, 1'b1});
            else        sb.push_back('{2'd1, a + b, 1'b0});
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: s_ready=%0b want 0", s_ready); end
        serve(-1, 2'd0, 32'd0, n, cv, d1, d2, ca, w, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_first_mvalid: no m_valid within budget"); end
        e = sb.pop_front();
        n_chk++; if (m_resp !== e.resp || m_data !== e.data || m_timeout !== e.to) begin n_fail++;
            $display("FAIL bp_result_0: got %0d/%0d/%0b want %0d/%0d/%0b", m_resp, m_data, m_timeout, e.resp, e.data, e.to); end
        m_ready = 1'b1; @(negedge clk);
        for (int i = 1; i < 5; i++) begin
            a = DW'(i * 16 + 1); b = DW'(i + 100);
            serve(1, 2'd1, a + b, n, cv, d1, d2, ca, w, ok);
            n_chk++; if (!ok || d1 !== a || d2 !== b) begin n_fail++;
                $display("FAIL bp_order_%0d: ok=%0b ops %0d,%0d want %0d,%0d", i, ok, d1, d2, a, b); end
            e = sb.pop_front();
            n_chk++; if (m_resp !== e.resp || m_data !== e.data || m_timeout !== e.to) begin n_fail++;
                $display("FAIL bp_result_%0d: got %0d/%0d/%0b want %0d/%0d/%0b", i, m_resp, m_data, m_timeout, e.resp, e.data, e.to); end
            @(negedge clk);
        end
        m_ready = 1'b0;
        n_chk++; if (busy !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: busy=%0b m_valid=%0b want 0,0", busy, m_valid); end
    endtask

    task automatic test_timeout();
        int n, ca, w; logic [CW-1:0] cv; logic [DW-1:0] d1, d2; bit ok;
        push(4'd2, 32'd9, 32'd3, 2'd0, 32'd0, 1'b1);
        serve(-1, 2'd0, 32'd0, n, cv, d1, d2, ca, w, ok);
        n_chk++; if (!ok || cv !== 4'd2) begin n_fail++; $display("FAIL to_mvalid: ok=%0b cmd=%0d want 1,2", ok, cv); end
        n_chk++; if (w !== TO + 1) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", w, TO + 1); end
        e = sb.pop_front();
        n_chk++; if (m_resp !== e.resp || m_data !== e.data || m_timeout !== e.to) begin n_fail++;
            $display("FAIL to_result: got %0d/%0d/%0b want %0d/%0d/%0b", m_resp, m_data, m_timeout, e.resp, e.data, e.to); end
        m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
        push(4'd1, 32'd4, 32'd4, 2'd1, 32'd8, 1'b0);
        serve(0, 2'd1, 32'd8, n, cv, d1, d2, ca, w, ok);
        n_chk++; if (!ok || w !== 1) begin n_fail++; $display("FAIL to_next_op: ok=%0b latency %0d want 1", ok, w); end
        e = sb.pop_front();
        n_chk++; if (m_resp !== e.resp || m_data !== e.data || m_timeout !== e.to) begin n_fail++;
            $display("FAIL to_next_result: got %0d/%0d/%0b want %0d/%0d/%0b", m_resp, m_data, m_timeout, e.resp, e.data, e.to); end
        m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    endtask

    task automatic test_spurious_race();
        int n, ca, w; logic [CW-1:0] cv; logic [DW-1:0] d1, d2; bit ok;
        n_chk++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL spur_clean: got %0b want 0", spurious); end
        out_resp = 2'd1; out_data = 32'd55; @(negedge clk); out_resp = '0; out_data = '0;
        n_chk++; if (spurious !== 1'b1) begin n_fail++; $display("FAIL spur_set: got %0b want 1", spurious); end
        @(negedge clk);
        n_chk++; if (m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL spur_no_result: m_valid=%0b busy=%0b want 0,0", m_valid, busy); end
        push(4'd1, 32'd2, 32'd3, 2'd1, 32'd77, 1'b0);
        serve(TO, 2'd1, 32'd77, n, cv, d1, d2, ca, w, ok);
        n_chk++; if (!ok || w !== TO + 1) begin n_fail++; $display("FAIL race_latency: ok=%0b got %0d want %0d", ok, w, TO + 1); end
        e = sb.pop_front();
        n_chk++; if (m_resp !== e.resp || m_data !== e.data || m_timeout !== e.to) begin n_fail++;
            $display("FAIL race_result: got %0d/%0d/%0b want %0d/%0d/%0b", m_resp, m_data, m_timeout, e.resp, e.data, e.to); end
        m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_cmd = 4'd1; s_op1 = DW'(i); s_op2 = DW'(i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if ({m_valid, m_timeout, busy, spurious} !== 4'b0 || s_ready !== 1'b1) begin n_fail++;
            $display("FAIL rstmid_flags: got %b ready %0b want 0000 ready 1", {m_valid, m_timeout, busy, spurious}, s_ready); end
        n_chk++; if ({m_resp, m_data, req_cmd_in, req_data_in} !== '0) begin n_fail++;
            $display("FAIL rstmid_data: got %h/%h/%h/%h want 0", m_resp, m_data, req_cmd_in, req_data_in); end
        rst = 1'b1;
        @(negedge clk);
        out_resp = 2'd1; out_data = 32'd99; @(negedge clk); out_resp = '0; out_data = '0;
        n_chk++; if (spurious !== 1'b1 || m_valid !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_late_resp: spurious=%0b m_valid=%0b want 1,0", spurious, m_valid); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0 || req_cmd_in !== '0 || m_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_fifo_empty: %0d active cycles want 0", bad); end
    endtask

    task automatic test_filter();
        int n, ca, w; logic [CW-1:0] cv; logic [DW-1:0] d1, d2; bit ok;
`ifdef CALC_CMD_FILTER_EN
        push(4'd3, 32'd1, 32'd1, 2'd2, 32'd0, 1'b0);
`else
        push(4'd3, 32'd1, 32'd1, 2'd1, 32'd2, 1'b0);
`endif
        serve(1, 2'd1, 32'd2, n, cv, d1, d2, ca, w, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL filt_mvalid: no m_valid within budget"); end
`ifdef CALC_CMD_FILTER_EN
        n_chk++; if (n !== 0) begin n_fail++; $display("FAIL filt_no_drive: %0d cmd cycles want 0", n); end
`else
        n_chk++; if (n !== 1 || cv !== 4'd3) begin n_fail++; $display("FAIL filt_forward: %0d cycles cmd %0d want 1 cycle cmd 3", n, cv); end
`endif
        e = sb.pop_front();
        n_chk++; if (m_resp !== e.resp || m_data !== e.data || m_timeout !== e.to) begin n_fail++;
            $display("FAIL filt_result: got %0d/%0d/%0b want %0d/%0d/%0b", m_resp, m_data, m_timeout, e.resp, e.data, e.to); end
        m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_cmd = '0; s_op1 = '0; s_op2 = '0;
        m_ready = 1'b0; out_resp = '0; out_data = '0;
        test_reset();
        test_add();
        test_backpressure();
        test_timeout();
        test_spurious_race();
        test_reset_mid();
        test_filter();
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_empty: %0d results outstanding want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
